voice_alloc: RTL

Polyphonic voice allocator for the sawtooth synth path. Accepts note-on/note-off events over a valid/ready handshake and converts each MIDI note number to an oscillator period through a registered lookup. It assigns each note to one of `NUM_VOICES` oscillator slots and drives every slot's enable and period inputs. It sits between the note/event source and the bank of `sawgen` oscillators, whose outputs are summed downstream.

---
 rtl/voice_pkg.sv | 23 ++
 rtl/voice_alloc_note_period_rom.sv | 25 ++
 rtl/voice_alloc.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/voice_pkg.sv
// Shared constants, FSM encoding and the note-to-period formula for the voice allocator.
package voice_pkg;

   localparam int CLK_HZ    = 48_000_000;
   localparam int NOTE_W    = 7;
   localparam int PERIOD_W  = 26;
   localparam int AGE_W     = 4;
   localparam int NUM_NOTES = 128;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEARCH = 2'd1,
      APPLY  = 2'd2
   } state_t;

   // Oscillator counts 0..period inclusive, hence the -1 after rounding.
   function automatic int note_period_calc(input int n);
      real f;
      f = 440.0 * (2.0 ** ((real'(n) - 69.0) / 12.0));
      return $rtoi(real'(CLK_HZ) / f + 0.5) - 1;
   endfunction

endpackage

// File: rtl/voice_alloc_note_period_rom.sv
// 128-entry note-to-period ROM with one-cycle registered read; contents built at elaboration.
module note_period_rom
   import voice_pkg::*;
#(
   parameter int PW = voice_pkg::PERIOD_W,
   parameter int NW = voice_pkg::NOTE_W
) (
   input  logic          clk,
   input  logic          rd_en,
   input  logic [NW-1:0] addr,
   output logic [PW-1:0] data
);

   logic [PW-1:0] rom [2**NW];

   for (genvar g = 0; g < 2**NW; g++) begin : g_rom
      localparam int P = note_period_calc(g);
      assign rom[g] = PW'(P);
   end

   always_ff @(posedge clk) begin
      if (rd_en) data <= rom[addr];
   end

endmodule

// File: rtl/voice_alloc.sv
// Polyphonic voice allocator. Define VOICE_STEAL_EN to steal the oldest slot when all
// slots are busy; otherwise such a note-on is dropped and the drop output pulses.
module voice_alloc
   import voice_pkg::*;
#(
   parameter int NUM_VOICES = 4,
   parameter int PERIOD_W   = voice_pkg::PERIOD_W,
   parameter int NOTE_W     = voice_pkg::NOTE_W
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           ev_valid,
   output logic                           ev_ready,
   input  logic                           ev_on,
   input  logic [NOTE_W-1:0]              ev_note,
   output logic [NUM_VOICES-1:0]          voice_en,
   output logic [NUM_VOICES*PERIOD_W-1:0] voice_period,
   output logic                           busy,
   output logic                           drop,
   output state_t                         state_dbg
);

   localparam int IDX_W = $clog2(NUM_VOICES);
   localparam logic [AGE_W-1:0] AGE_MAX = '1;

   // Handshake: an event transfers on a rising edge where ev_valid and ev_ready are both
   // high; ev_on/ev_note are sampled only on that edge and ev_valid may stay high meanwhile.
   state_t               state;
   logic [IDX_W-1:0]     scan_idx;
   logic                 on_q;
   logic [NOTE_W-1:0]    note_q;
   logic [NUM_VOICES-1:0] en;
   logic [NOTE_W-1:0]    slot_note   [NUM_VOICES];
   logic [PERIOD_W-1:0]  slot_period [NUM_VOICES];
   logic [AGE_W-1:0]     slot_age    [NUM_VOICES];
   logic                 match_ok, free_ok;
   logic [IDX_W-1:0]     match_idx, free_idx;
`ifdef VOICE_STEAL_EN
   logic                 old_ok;
   logic [IDX_W-1:0]     old_idx;
   logic [AGE_W-1:0]     old_age;
`endif
   logic [PERIOD_W-1:0]  rom_data;
   logic                 hs;
   logic                 tgt_ok;
   logic [IDX_W-1:0]     tgt_idx;
   logic                 drop_now;
   logic                 off_hit;

   assign ev_ready = (state == IDLE);
   assign hs       = ev_valid & ev_ready;

   note_period_rom #(.PW(PERIOD_W), .NW(NOTE_W)) u_rom (
      .clk  (clk),
      .rd_en(hs),
      .addr (ev_note),
      .data (rom_data)
   );

   always_comb begin
      tgt_ok  = 1'b0;
      tgt_idx = '0;
      if (on_q) begin
         if (match_ok) begin
            tgt_ok  = 1'b1;
            tgt_idx = match_idx;
         end else if (free_ok) begin
            tgt_ok  = 1'b1;
            tgt_idx = free_idx;
         end
`ifdef VOICE_STEAL_EN
         else begin
            tgt_ok  = old_ok;
            tgt_idx = old_idx;
         end
`endif
      end
   end

   assign drop_now = on_q & ~tgt_ok;
   assign off_hit  = ~on_q & match_ok;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         scan_idx  <= '0;
         on_q      <= 1'b0;
         note_q    <= '0;
         en        <= '0;
         drop      <= 1'b0;
         match_ok  <= 1'b0;
         free_ok   <= 1'b0;
         match_idx <= '0;
         free_idx  <= '0;
`ifdef VOICE_STEAL_EN
         old_ok    <= 1'b0;
         old_idx   <= '0;
         old_age   <= '0;
`endif
         for (int i = 0; i < NUM_VOICES; i++) begin
            slot_note[i]   <= '0;
            slot_period[i] <= '0;
            slot_age[i]    <= '0;
         end
      end else begin
         drop <= 1'b0;
         case (state)
            IDLE: begin
               if (hs) begin
                  on_q     <= ev_on;
                  note_q   <= ev_note;
                  scan_idx <= '0;
                  match_ok <= 1'b0;
                  free_ok  <= 1'b0;
`ifdef VOICE_STEAL_EN
                  old_ok   <= 1'b0;
`endif
                  state    <= SEARCH;
               end
            end
            SEARCH: begin
               if (!match_ok && en[scan_idx] && slot_note[scan_idx] == note_q) begin
                  match_ok  <= 1'b1;
                  match_idx <= scan_idx;
               end
               if (!free_ok && !en[scan_idx]) begin
                  free_ok  <= 1'b1;
                  free_idx <= scan_idx;
               end
`ifdef VOICE_STEAL_EN
               // Strict greater-than keeps the lowest index on equal ages.
               if (en[scan_idx] && (!old_ok || slot_age[scan_idx] > old_age)) begin
                  old_ok  <= 1'b1;
                  old_idx <= scan_idx;
                  old_age <= slot_age[scan_idx];
               end
`endif
               if (scan_idx == IDX_W'(NUM_VOICES - 1)) state <= APPLY;
               else scan_idx <= scan_idx + 1'b1;
            end
            APPLY: begin
               state <= IDLE;
               drop  <= drop_now;
               for (int i = 0; i < NUM_VOICES; i++) begin
                  if (tgt_ok) begin
                     if (IDX_W'(i) == tgt_idx) begin
                        en[i]          <= 1'b1;
                        slot_note[i]   <= note_q;
                        slot_period[i] <= rom_data;
                        slot_age[i]    <= '0;
                     end else if (en[i] && slot_age[i] != AGE_MAX) begin
                        slot_age[i] <= slot_age[i] + 1'b1;
                     end
                  end else if (off_hit && IDX_W'(i) == match_idx) begin
                     en[i]          <= 1'b0;
                     slot_period[i] <= '0;
                     slot_age[i]    <= '0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign voice_en  = en;
   assign busy      = (state != IDLE);
   assign state_dbg = state;

   for (genvar g = 0; g < NUM_VOICES; g++) begin : g_out
      assign voice_period[g*PERIOD_W +: PERIOD_W] = slot_period[g];
   end

endmodule
